// File: rtl/mac_pkg.sv
// mac_pkg: shared types and helpers for the multiply-accumulate engine.
//   state_t       - IDLE / RUN / DONE sequencing states
//   acc_width()   - accumulator width that cannot overflow for N taps of DW x DW
//   sat_*()       - clamp bounds at output width AW, evaluated in a wide signed
//                   type so they compare directly against the extended accumulator
package mac_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Widest accumulator / output the bound helpers can represent.
    localparam int MAX_W = 128;
    typedef logic signed [MAX_W-1:0] wide_t;

    // Full product is 2*DW bits; summing N of them needs clog2(N) more; one
    // extra bit keeps the unsigned sum positive when viewed as signed.
    function automatic int acc_width(input int n, input int dw);
        return 2 * dw + $clog2(n) + 1;
    endfunction

    function automatic wide_t sat_max_s(input int aw);
        return (wide_t'(1) <<< (aw - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t sat_min_s(input int aw);
        return -(wide_t'(1) <<< (aw - 1));
    endfunction

    function automatic wide_t sat_max_u(input int aw);
        return (wide_t'(1) <<< aw) - wide_t'(1);
    endfunction

endpackage

// File: rtl/mac_lane.sv
// mac_lane: one combinational DW x DW multiplier, result extended to ACCW.
//   a, b  - operands
//   sgn   - 1: two's-complement operands, sign-extend; 0: unsigned, zero-extend
//   prod  - ACCW-bit product ready to add into the accumulator
module mac_lane #(
    parameter int DW   = 16,
    parameter int ACCW = 36
) (
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    input  logic            sgn,
    output logic [ACCW-1:0] prod
);

    logic signed [2*DW-1:0] prod_s;
    logic        [2*DW-1:0] prod_u;

    // Operands widened explicitly so the multiply is done at full 2*DW width.
    assign prod_s = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
    assign prod_u = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};

    assign prod = sgn ? {{(ACCW-2*DW){prod_s[2*DW-1]}}, prod_s}
                      : {{(ACCW-2*DW){1'b0}}, prod_u};

endmodule

// File: rtl/mac_engine.sv
// mac_engine: N-tap dot product, P products per cycle.
//   clk, reset      - clock; asynchronous active-low reset
//   start           - begin an operation (sampled only in IDLE)
//   d, cmem         - N packed DW-bit data / coefficient elements
//   mode_signed     - signed operands when 1
//   sat_en          - clamp to AW range when 1, wrap when 0
//   out, ovf        - registered result and out-of-range flag, held until next DONE
//   done            - one-cycle pulse as out/ovf update
//   busy            - high from capture edge up to the edge that raises done
module mac_engine
    import mac_pkg::*;
#(
    parameter int N  = 8,
    parameter int DW = 16,
    parameter int AW = 32,
    parameter int P  = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [N*DW-1:0] d,
    input  logic [N*DW-1:0] cmem,
    input  logic          mode_signed,
    input  logic          sat_en,
    output logic [AW-1:0] out,
    output logic          done,
    output logic          busy,
    output logic          ovf
);

    localparam int ACCW = acc_width(N, DW);
    localparam int KW   = $clog2(N + 1);

    generate
        if (N % P != 0) begin : g_bad_p
            $error("mac_engine: P (%0d) must divide N (%0d)", P, N);
        end
        if (ACCW >= MAX_W || AW >= MAX_W || AW < 2) begin : g_bad_w
            $error("mac_engine: unsupported widths ACCW=%0d AW=%0d", ACCW, AW);
        end
    endgenerate

    state_t state, state_nx;

    logic [N*DW-1:0] d_q, c_q;
    logic            sgn_q, sat_q;
    logic [KW-1:0]   k;
    logic [ACCW-1:0] acc;

    logic [P-1:0][DW-1:0]   lane_a, lane_b;
    logic [P-1:0][ACCW-1:0] lane_p;
    logic [ACCW-1:0]        step_sum;

    // Taps k..k+P-1 feed the lanes this cycle.
    always_comb begin
        for (int j = 0; j < P; j++) begin
            lane_a[j] = d_q[(int'(k) + j) * DW +: DW];
            lane_b[j] = c_q[(int'(k) + j) * DW +: DW];
        end
    end

    generate
        for (genvar j = 0; j < P; j++) begin : g_lane
            mac_lane #(.DW(DW), .ACCW(ACCW)) u_lane (
                .a    (lane_a[j]),
                .b    (lane_b[j]),
                .sgn  (sgn_q),
                .prod (lane_p[j])
            );
        end
    endgenerate

    // Two's-complement addition at ACCW bits is exact for both modes.
    always_comb begin
        step_sum = '0;
        for (int j = 0; j < P; j++) step_sum = step_sum + lane_p[j];
    end

    // ---------------- sequencing ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (k == KW'(N - P)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // ---------------- result narrowing ----------------
    wide_t         acc_w;
    logic          hi, lo;
    logic [AW-1:0] res;

    always_comb begin
        // Unsigned sums are never negative, so only signed mode sign-extends.
        acc_w = {{(MAX_W-ACCW){sgn_q & acc[ACCW-1]}}, acc};
        if (sgn_q) begin
            hi = acc_w > sat_max_s(AW);
            lo = acc_w < sat_min_s(AW);
        end else begin
            hi = acc_w > sat_max_u(AW);
            lo = 1'b0;
        end
        res = acc_w[AW-1:0];
        if (sat_q && hi) begin
            res = '1;
            if (sgn_q) res[AW-1] = 1'b0;
        end else if (sat_q && lo) begin
            res = '0;
            res[AW-1] = 1'b1;
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_q   <= '0;
            c_q   <= '0;
            sgn_q <= 1'b0;
            sat_q <= 1'b0;
            k     <= '0;
            acc   <= '0;
            out   <= '0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    d_q   <= d;
                    c_q   <= cmem;
                    sgn_q <= mode_signed;
                    sat_q <= sat_en;
                    acc   <= '0;
                    k     <= '0;
                end
                RUN: begin
                    acc <= acc + step_sum;
                    // Wrap back to 0 on the last step so k never indexes past N.
                    k   <= (k == KW'(N - P)) ? '0 : k + KW'(P);
                end
                DONE: begin
                    out  <= res;
                    ovf  <= hi | lo;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_engine.sv
// tb_mac_engine: drives two engines (P=1 and P=2, N=8, DW=16, AW=32) with
// directed and random operations and checks them against a plain-arithmetic
// dot-product model.
module tb_mac_engine;

    localparam int N  = 8;
    localparam int DW = 16;
    localparam int AW = 32;
    localparam int VW = N * DW;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [1:0] start, sg, st, done, busy, ovf;
    logic [1:0][VW-1:0] dv, cv;
    logic [1:0][AW-1:0] out;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mac_engine #(.N(N), .DW(DW), .AW(AW), .P(1)) u_p1 (
        .clk(clk), .reset(reset), .start(start[0]), .d(dv[0]), .cmem(cv[0]),
        .mode_signed(sg[0]), .sat_en(st[0]), .out(out[0]), .done(done[0]),
        .busy(busy[0]), .ovf(ovf[0])
    );

    mac_engine #(.N(N), .DW(DW), .AW(AW), .P(2)) u_p2 (
        .clk(clk), .reset(reset), .start(start[1]), .d(dv[1]), .cmem(cv[1]),
        .mode_signed(sg[1]), .sat_en(st[1]), .out(out[1]), .done(done[1]),
        .busy(busy[1]), .ovf(ovf[1])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer dot product, then range check / clamp / wrap.
    function automatic void model(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                  input logic s, input logic t,
                                  output logic [AW-1:0] o, output logic v);
        longint sum, lo, hi, x, y;
        logic [DW-1:0] ea, eb;
        sum = 0;
        for (int i = 0; i < N; i++) begin
            ea = a[i*DW +: DW];
            eb = b[i*DW +: DW];
            if (s) begin
                x = longint'($signed(ea));
                y = longint'($signed(eb));
            end else begin
                x = longint'(ea);
                y = longint'(eb);
            end
            sum += x * y;
        end
        if (s) begin
            lo = -64'sh8000_0000;
            hi = 64'sh7FFF_FFFF;
        end else begin
            lo = 0;
            hi = 64'sh FFFF_FFFF;
        end
        v = (sum < lo) || (sum > hi);
        if (t && sum > hi)      o = hi[AW-1:0];
        else if (t && sum < lo) o = lo[AW-1:0];
        else                    o = sum[AW-1:0];
    endfunction

    function automatic logic [DW-1:0] rnd_elem();
        case ($urandom_range(0, 4))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'hFFFF;
            default: return DW'($urandom);
        endcase
    endfunction

    function automatic logic [VW-1:0] rnd_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = rnd_elem();
        return v;
    endfunction

    function automatic logic [VW-1:0] ramp(input int base, input int step);
        logic [VW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(base + i * step);
        return v;
    endfunction

    // One operation on unit u. Inputs are scrambled right after capture; with
    // mid set, a start pulse and a data change land in cycle 3 of the run.
    task automatic run_op(input int u, input logic [VW-1:0] a, input logic [VW-1:0] b,
                          input logic s, input logic t, input bit mid, input string tag);
        logic [AW-1:0] eo;
        logic ev;
        int n, bc, lat;
        lat = (u == 0) ? N + 1 : N / 2 + 1;
        model(a, b, s, t, eo, ev);
        @(negedge clk);
        dv[u] = a; cv[u] = b; sg[u] = s; st[u] = t; start[u] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[u] = 1'b0;
        dv[u] = rnd_vec(); cv[u] = rnd_vec(); sg[u] = ~s; st[u] = ~t;
        n = 0; bc = 0;
        while (!done[u] && n < 60) begin
            if (busy[u]) bc++;
            if (mid && n == 2) begin start[u] = 1'b1; dv[u] = rnd_vec(); end
            if (mid && n == 3) start[u] = 1'b0;
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk({tag, "_busycyc"}, 64'(bc), 64'(lat));
        chk({tag, "_busy_at_done"}, 64'(busy[u]), 64'(0));
        chk({tag, "_out"}, 64'(out[u]), 64'(eo));
        chk({tag, "_ovf"}, 64'(ovf[u]), 64'(ev));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(done[u]), 64'(0));
        chk({tag, "_no_restart"}, 64'(busy[u]), 64'(0));
        chk({tag, "_out_hold"}, 64'(out[u]), 64'(eo));
    endtask

    initial begin
        logic [VW-1:0] a, b;
        logic [AW-1:0] eo;
        logic ev;
        int n, seen;

        start = '0; sg = '0; st = '0; dv = '0; cv = '0;
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("rst_out", 64'(out[u]), 64'(0));
            chk("rst_done", 64'(done[u]), 64'(0));
            chk("rst_busy", 64'(busy[u]), 64'(0));
            chk("rst_ovf", 64'(ovf[u]), 64'(0));
        end
        reset = 1'b1;

        // Directed cases with known answers.
        run_op(0, ramp(1, 1), ramp(1, 0), 1'b0, 1'b0, 1'b0, "ramp_u");
        chk("ramp_u_const", 64'(out[0]), 64'd36);
        run_op(0, ramp(16'hFFFF, 0), ramp(2, 0), 1'b1, 1'b0, 1'b0, "neg_s");
        chk("neg_s_const", 64'(out[0]), 64'hFFFF_FFF0);
        run_op(0, ramp(16'hFFFF, 0), ramp(16'hFFFF, 0), 1'b0, 1'b0, 1'b0, "max_wrap");
        chk("max_wrap_const", 64'(out[0]), 64'hFFF0_0008);
        run_op(0, ramp(16'hFFFF, 0), ramp(16'hFFFF, 0), 1'b0, 1'b1, 1'b0, "max_sat");
        chk("max_sat_const", 64'(out[0]), 64'hFFFF_FFFF);
        chk("max_sat_ovf", 64'(ovf[0]), 64'd1);
        run_op(0, ramp(16'h8000, 0), ramp(16'h8000, 0), 1'b1, 1'b1, 1'b0, "smax_sat");
        run_op(0, ramp(16'h8000, 0), ramp(16'h7FFF, 0), 1'b1, 1'b1, 1'b0, "smin_sat");
        run_op(0, ramp(3, 5), ramp(7, 1), 1'b0, 1'b0, 1'b1, "mid_start");
        run_op(1, ramp(1, 1), ramp(1, 1), 1'b0, 1'b0, 1'b0, "p2_ramp");
        chk("p2_ramp_const", 64'(out[1]), 64'd204);

        // start held high: second op captured at the first IDLE edge.
        a = ramp(1, 1); b = ramp(1, 0);
        @(negedge clk);
        dv[0] = a; cv[0] = b; sg[0] = 1'b0; st[0] = 1'b0; start[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n = 0;
        while (!done[0] && n < 60) begin @(negedge clk); n++; end
        chk("b2b_lat1", 64'(n), 64'(N + 1));
        chk("b2b_out1", 64'(out[0]), 64'd36);
        a = rnd_vec(); b = rnd_vec();
        dv[0] = a; cv[0] = b; sg[0] = 1'b1; st[0] = 1'b1;
        model(a, b, 1'b1, 1'b1, eo, ev);
        n = 0;
        do begin @(negedge clk); n++; end while (!done[0] && n < 60);
        start[0] = 1'b0;
        chk("b2b_gap", 64'(n), 64'(N + 2));
        chk("b2b_out2", 64'(out[0]), 64'(eo));
        chk("b2b_ovf2", 64'(ovf[0]), 64'(ev));

        // Make ovf=1 beforehand so the asynchronous clear is visible.
        run_op(0, ramp(16'hFFFF, 0), ramp(16'hFFFF, 0), 1'b0, 1'b1, 1'b0, "pre_rst");
        @(negedge clk);
        dv[0] = ramp(2, 3); cv[0] = ramp(5, 1); sg[0] = 1'b0; st[0] = 1'b0; start[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[0] = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_out", 64'(out[0]), 64'(0));
        chk("arst_ovf", 64'(ovf[0]), 64'(0));
        chk("arst_busy", 64'(busy[0]), 64'(0));
        chk("arst_done", 64'(done[0]), 64'(0));
        chk("arst_out_p2", 64'(out[1]), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (12) begin @(negedge clk); if (done[0] || busy[0]) seen++; end
        chk("arst_quiet", 64'(seen), 64'(0));
        run_op(0, ramp(2, 3), ramp(5, 1), 1'b0, 1'b0, 1'b0, "post_rst");

        // Random operations.
        for (int i = 0; i < 20; i++)
            run_op(0, rnd_vec(), rnd_vec(), 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0), "rnd_p1");
        for (int i = 0; i < 10; i++)
            run_op(1, rnd_vec(), rnd_vec(), 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0), "rnd_p2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
